// File: rtl/rr_arbiter_if.sv
// Request/grant bundle shared by the round-robin arbiter and its requesters.
// The requester side drives req; the arbiter side drives the registered grant outputs.
interface rr_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a bounded hold time per grant and fully registered outputs.
// A two-state FSM (IDLE/GRANT) tracks the owner; the search pointer rotates on every release.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  rr_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;

  logic [N-1:0]  req;
  logic [IW-1:0] owner_inc;
  logic [IW-1:0] search_start;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          release_cond;

  assign req = bus.req;

  // Explicit wrap keeps the index inside 0..N-1 when N is not a power of two.
  assign owner_inc = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

  assign release_cond = !req[owner] || (hold_cnt == HW'(MAX_HOLD - 1));

  // Rotating priority search: first set request at or after search_start, wrapping.
  always_comb begin
    int cand;
    search_start = (state == GRANT) ? owner_inc : ptr;
    win_found    = 1'b0;
    win_idx      = '0;
    cand         = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(search_start) + k;
      if (cand >= N) cand = cand - N;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // State register: FSM state, pointer, owner, hold counter and the output registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    hold_nxt  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          owner_nxt = win_idx;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (release_cond) begin
          ptr_nxt = owner_inc;
          if (win_found) begin
            // A sole requester that timed out is found last and re-granted here.
            owner_nxt = win_idx;
            hold_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: decode the next owner into the values the output registers load.
  always_comb begin
    grant_d = '0;
    idx_d   = '0;
    valid_d = 1'b0;
    if (state_nxt == GRANT) begin
      grant_d[owner_nxt] = 1'b1;
      idx_d              = owner_nxt;
      valid_d            = 1'b1;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for the timeout, full-load, reset and N=3 cases.
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic reset4;
  logic reset3;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rr_arbiter_if #(.N(4)) bus4 ();
  rr_arbiter_if #(.N(3)) bus3 ();

  rr_arbiter #(.N(4), .MAX_HOLD(8)) u_dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4.slave)
  );

  rr_arbiter #(.N(3), .MAX_HOLD(2)) u_dut3 (
    .clk   (clk),
    .reset (reset3),
    .bus   (bus3.slave)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [1:0] exp_idx;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step4(input logic rst, input logic [3:0] r);
    reset4   = rst;
    bus4.req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic rst, input logic [2:0] r);
    reset3   = rst;
    bus3.req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out4(input string name, input logic [3:0] g, input logic [1:0] i,
                            input logic v);
    check({name, "_grant"}, 32'(bus4.grant), 32'(g));
    check({name, "_idx"},   32'(bus4.grant_idx), 32'(i));
    check({name, "_valid"}, 32'(bus4.grant_valid), 32'(v));
  endtask

  initial begin
    reset4   = 1'b1;
    reset3   = 1'b1;
    bus4.req = '0;
    bus3.req = '0;

    //        rst   req      grant    idx  valid
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0}; // reset state
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0}; // idle stays idle
    tbl[2]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1}; // one-cycle grant latency
    tbl[3]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[4]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0}; // early release, ptr -> 2
    tbl[6]  = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1}; // search from 2 finds 3
    tbl[7]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1}; // 3 released, wrap to 0
    tbl[8]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1}; // 0 released, 1 next
    tbl[9]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1}; // back-to-back to 3
    tbl[10] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1}; // held
    tbl[11] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1}; // wrap past 0 to 1
    tbl[12] = '{1'b0, 4'b0111, 4'b0010, 2'd1, 1'b1}; // other bits do not disturb owner
    tbl[13] = '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1}; // release to 2
    tbl[14] = '{1'b1, 4'b0101, 4'b0000, 2'd0, 1'b0}; // reset wins mid-grant
    tbl[15] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1}; // first search after reset from 0

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      step4(tbl[i].rst, tbl[i].req);
      check_out4($sformatf("tbl%0d", i), tbl[i].exp_grant, tbl[i].exp_idx, tbl[i].exp_valid);
      check($sformatf("tbl%0d_onehot", i), 32'($onehot0(bus4.grant)), 32'd1);
    end

    // Reset mid-grant: owner 2 at hold_cnt 3, one-cycle reset pulse.
    step4(1'b1, 4'b0000);
    for (int c = 0; c < 4; c++) step4(1'b0, 4'b0100);
    check("midgrant_hold", 32'(u_dut4.hold_cnt), 32'd3);
    check_out4("midgrant_before", 4'b0100, 2'd2, 1'b1);
    step4(1'b1, 4'b0100);
    check_out4("midgrant_reset", 4'b0000, 2'd0, 1'b0);
    step4(1'b0, 4'b0100);
    check_out4("midgrant_after", 4'b0100, 2'd2, 1'b1);

    // Full load: each requester held exactly 8 cycles, no gaps.
    step4(1'b1, 4'b0000);
    for (int c = 0; c < 40; c++) begin
      step4(1'b0, 4'b1111);
      check($sformatf("full_idx_c%0d", c), 32'(bus4.grant_idx), 32'((c / 8) % 4));
      check($sformatf("full_valid_c%0d", c), 32'(bus4.grant_valid), 32'd1);
    end

    // Sole requester: continuous grant, hold counter restarts every 8 cycles.
    step4(1'b1, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      step4(1'b0, 4'b0001);
      check_out4($sformatf("sole_c%0d", c), 4'b0001, 2'd0, 1'b1);
      check($sformatf("sole_hold_c%0d", c), 32'(u_dut4.hold_cnt), 32'(c % 8));
    end

    // N=3, MAX_HOLD=2: index sequence 0,0,1,1,2,2,0,... never 3.
    step3(1'b1, 3'b000);
    check("n3_reset_valid", 32'(bus3.grant_valid), 32'd0);
    for (int c = 0; c < 12; c++) begin
      step3(1'b0, 3'b111);
      check($sformatf("n3_idx_c%0d", c), 32'(bus3.grant_idx), 32'((c / 2) % 3));
      check($sformatf("n3_grant_c%0d", c), 32'(bus3.grant), 32'(3'b001 << ((c / 2) % 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
